// File: rtl/sdr_pkg.sv
// rtl/sdr_pkg.sv - shared SDR peripheral constants and types
package sdr_pkg;

  localparam int PHASE_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2
  } meter_state_t;

  // Last SETTLE count before entering GATE (three SETTLE cycles: 0,1,2).
  localparam logic [1:0] SETTLE_LAST = 2'd2;

endpackage

// File: rtl/nco_freq_meter_if.sv
// rtl/nco_freq_meter_if.sv - measurement result channel with valid/ready handshake
interface nco_freq_meter_if #(
  parameter int GATE_LOG2 = 24
);
  import sdr_pkg::*;

  logic [PHASE_W-1:0] phase_inc_meas;
  logic [GATE_LOG2:0] edge_count;
  logic               meas_valid;
  logic               meas_ready;
  logic               overrun;

  modport master (
    output phase_inc_meas,
    output edge_count,
    output meas_valid,
    output overrun,
    input  meas_ready
  );

  modport slave (
    input  phase_inc_meas,
    input  edge_count,
    input  meas_valid,
    input  overrun,
    output meas_ready
  );

endinterface

// File: rtl/sig_sync_edge.sv
// rtl/sig_sync_edge.sv - 2-FF synchronizer with rising-edge detect for async inputs
module sig_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic dly;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign rise = sync2 & ~dly;

endmodule

// File: rtl/nco_freq_meter.sv
// rtl/nco_freq_meter.sv - gated edge counter reporting frequency as an NCO tuning word
module nco_freq_meter
  import sdr_pkg::*;
#(
  parameter int GATE_LOG2 = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic sig_in,
  nco_freq_meter_if.master meas
);

  localparam int SHIFT = PHASE_W - GATE_LOG2;

  if (GATE_LOG2 < 4 || GATE_LOG2 > 63) begin : g_bad_gate
    $error("nco_freq_meter: GATE_LOG2 out of range 4..63");
  end

  meter_state_t         state;
  meter_state_t         state_nxt;
  logic [1:0]           settle_cnt;
  logic [GATE_LOG2-1:0] gate_cnt;
  logic [GATE_LOG2:0]   edge_acc;
  logic [GATE_LOG2:0]   edge_total;
  logic [PHASE_W-1:0]   phase_word;
  logic                 rise;
  logic                 gate_done;
  logic                 handshake;

  sig_sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise   (rise)
  );

  // A rise on the terminal cycle still belongs to the gate that is ending.
  assign edge_total = edge_acc + (GATE_LOG2 + 1)'(rise);
  assign gate_done  = (state == GATE) && enable && (gate_cnt == '1);
  assign handshake  = meas.meas_valid && meas.meas_ready;
  assign phase_word = PHASE_W'(edge_total) << SHIFT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = GATE;
      GATE:    state_nxt = GATE;
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  // Gate counter wraps on terminal count so consecutive gates abut with no dead cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      gate_cnt   <= '0;
      edge_acc   <= '0;
    end else begin
      case (state)
        SETTLE: begin
          settle_cnt <= settle_cnt + 2'd1;
        end
        GATE: begin
          gate_cnt <= gate_cnt + GATE_LOG2'(1);
          edge_acc <= gate_done ? '0 : edge_total;
        end
        default: begin
          settle_cnt <= '0;
          gate_cnt   <= '0;
          edge_acc   <= '0;
        end
      endcase
    end
  end

  // A new result and a handshake in the same cycle: the new result stays valid, the old one is consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meas.phase_inc_meas <= '0;
      meas.edge_count     <= '0;
      meas.meas_valid     <= 1'b0;
      meas.overrun        <= 1'b0;
    end else if (gate_done) begin
      meas.phase_inc_meas <= phase_word;
      meas.edge_count     <= edge_total;
      meas.meas_valid     <= 1'b1;
      meas.overrun        <= (meas.overrun || meas.meas_valid) && !handshake;
    end else if (handshake) begin
      meas.meas_valid     <= 1'b0;
      meas.overrun        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nco_freq_meter.sv
// tb/tb_nco_freq_meter.sv - self-checking bench for nco_freq_meter with a window-counting reference model
module tb_nco_freq_meter;

  localparam int GL      = 8;
  localparam int GLEN    = 256;
  localparam int LAT_EN  = 4;
  localparam int MAXC    = 16384;
  localparam logic [63:0] UNIT = 64'h0100_0000_0000_0000;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic enable = 1'b0;
  logic sig_in = 1'b0;

  nco_freq_meter_if #(.GATE_LOG2(GL)) mif ();

  nco_freq_meter #(.GATE_LOG2(GL)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .sig_in (sig_in),
    .meas   (mif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit hist [MAXC];
  int en_start = -1;
  bit m_valid = 1'b0;
  bit m_over  = 1'b0;
  int m_cnt   = 0;
  int sig_mode = 0;
  int sig_p    = 2;
  int sig_ph   = 0;
  int rdy_mode = 1;

  function automatic bit gen_sig(input int c);
    case (sig_mode)
      1:       return 1'b1;
      2:       return ((c + sig_ph) % sig_p) < (sig_p / 2);
      3:       return 1'($urandom_range(0, 1));
      4:       return c >= sig_ph;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int rises(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (hist[c] && !hist[c-1]) n++;
    return n;
  endfunction

  function automatic int next_result();
    int r = en_start + LAT_EN + GLEN;
    while (r <= cyc) r += GLEN;
    return r;
  endfunction

  task automatic set_enable(input bit v);
    enable = v;
    if (!v) en_start = -1;
    else if (en_start < 0) en_start = cyc;
  endtask

  // Model: a result appears LAT_EN+GLEN cycles after enable, then every GLEN cycles,
  // counting input rises that occurred between 258 and 3 cycles earlier.
  task automatic step();
    bit hs;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_valid = 1'b0; m_over = 1'b0; m_cnt = 0;
      en_start = enable ? cyc : -1;
    end else begin
      hs = m_valid && mif.meas_ready;
      if (enable && en_start >= 0 && cyc >= en_start + LAT_EN + GLEN &&
          ((cyc - en_start - LAT_EN - GLEN) % GLEN) == 0) begin
        m_cnt   = rises(cyc - GLEN - 2, cyc - 3);
        m_over  = (m_over || m_valid) && !hs;
        m_valid = 1'b1;
      end else if (hs) begin
        m_valid = 1'b0; m_over = 1'b0;
      end
    end
    #1;
    sig_in = gen_sig(cyc);
    hist[cyc] = sig_in;
    if (rdy_mode == 0) mif.meas_ready = 1'b0;
    else if (rdy_mode == 1) mif.meas_ready = 1'b1;
    else mif.meas_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      checks++;
      if (mif.meas_valid !== m_valid || mif.overrun !== m_over ||
          mif.edge_count !== 9'(m_cnt) || mif.phase_inc_meas !== 64'(m_cnt) * UNIT) begin
        errors++;
        $display("FAIL model cyc=%0d valid=%b exp %b overrun=%b exp %b count=%0d exp %0d phase=%h exp %h",
                 cyc, mif.meas_valid, m_valid, mif.overrun, m_over, mif.edge_count, m_cnt,
                 mif.phase_inc_meas, 64'(m_cnt) * UNIT);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run(3);
    checks++;
    if (mif.meas_valid !== 1'b0 || mif.overrun !== 1'b0 ||
        mif.edge_count !== 9'd0 || mif.phase_inc_meas !== 64'd0) begin
      errors++;
      $display("FAIL reset valid=%b overrun=%b count=%0d phase=%h required all zero",
               mif.meas_valid, mif.overrun, mif.edge_count, mif.phase_inc_meas);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_period16();
    int r;
    sig_mode = 2; sig_p = 16; sig_ph = $urandom_range(0, 15); rdy_mode = 1;
    set_enable(1'b1);
    r = en_start + LAT_EN + GLEN;
    run(r - cyc - 1);
    checks++;
    if (mif.meas_valid !== 1'b0) begin
      errors++; $display("FAIL first_latency_early valid=%b required 0", mif.meas_valid);
    end
    for (int g = 0; g < 3; g++) begin
      run(g == 0 ? 1 : GLEN);
      checks++;
      if (mif.meas_valid !== 1'b1 || mif.edge_count !== 9'd16 ||
          mif.phase_inc_meas !== 64'h1000_0000_0000_0000 || mif.overrun !== 1'b0) begin
        errors++;
        $display("FAIL period16 gate=%0d valid=%b count=%0d phase=%h overrun=%b required 1/16/1000000000000000/0",
                 g, mif.meas_valid, mif.edge_count, mif.phase_inc_meas, mif.overrun);
      end
    end
  endtask

  task automatic test_toggle_and_constant();
    sig_mode = 2; sig_p = 2;
    run(2 * GLEN);
    checks++;
    if (mif.edge_count !== 9'd128 || mif.phase_inc_meas !== 64'h8000_0000_0000_0000) begin
      errors++;
      $display("FAIL toggle count=%0d phase=%h required 128/8000000000000000", mif.edge_count, mif.phase_inc_meas);
    end
    sig_mode = $urandom_range(0, 1);
    run(2 * GLEN);
    checks++;
    if (mif.edge_count !== 9'd0 || mif.phase_inc_meas !== 64'd0 || mif.meas_valid !== 1'b1) begin
      errors++;
      $display("FAIL constant count=%0d phase=%h valid=%b required 0/0/1", mif.edge_count, mif.phase_inc_meas, mif.meas_valid);
    end
  endtask

  task automatic test_random();
    rdy_mode = 2;
    for (int g = 0; g < 6; g++) begin
      if ($urandom_range(0, 1) == 0) begin
        sig_mode = 2; sig_p = $urandom_range(2, 40); sig_ph = $urandom_range(0, 39);
      end else begin
        sig_mode = 3;
      end
      run(GLEN + $urandom_range(0, 40));
    end
  endtask

  task automatic test_terminal_edge();
    int r;
    rdy_mode = 1; sig_mode = 0;
    run(GLEN + 4);
    run(next_result() - cyc);
    r = cyc + GLEN;
    sig_mode = 4; sig_ph = r - 3;
    run(GLEN);
    checks++;
    if (mif.edge_count !== 9'd1) begin
      errors++; $display("FAIL terminal_edge_in_gate count=%0d required 1", mif.edge_count);
    end
    run(GLEN);
    checks++;
    if (mif.edge_count !== 9'd0) begin
      errors++; $display("FAIL terminal_edge_next_gate count=%0d required 0", mif.edge_count);
    end
  endtask

  task automatic test_backpressure();
    sig_mode = 2; sig_p = $urandom_range(2, 30); rdy_mode = 1;
    run(next_result() - cyc);
    rdy_mode = 0; mif.meas_ready = 1'b0;
    run(GLEN);
    checks++;
    if (mif.meas_valid !== 1'b1 || mif.overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set valid=%b overrun=%b required 1/1", mif.meas_valid, mif.overrun);
    end
    sig_p = $urandom_range(2, 30);
    run(GLEN);
    checks++;
    if (mif.meas_valid !== 1'b1 || mif.overrun !== 1'b1 || mif.edge_count !== 9'(rises(cyc - GLEN - 2, cyc - 3))) begin
      errors++;
      $display("FAIL overrun_second valid=%b overrun=%b count=%0d required 1/1/%0d",
               mif.meas_valid, mif.overrun, mif.edge_count, rises(cyc - GLEN - 2, cyc - 3));
    end
    mif.meas_ready = 1'b1;
    run(1);
    checks++;
    if (mif.meas_valid !== 1'b0 || mif.overrun !== 1'b0) begin
      errors++; $display("FAIL accept_clears valid=%b overrun=%b required 0/0", mif.meas_valid, mif.overrun);
    end
  endtask

  task automatic test_enable_drop();
    int old;
    rdy_mode = 1; sig_mode = 2; sig_p = $urandom_range(2, 30);
    run(next_result() - cyc);
    old = m_cnt;
    run(100);
    set_enable(1'b0);
    run(400);
    checks++;
    if (mif.meas_valid !== 1'b0 || mif.edge_count !== 9'(old)) begin
      errors++; $display("FAIL enable_drop valid=%b count=%0d required 0/%0d", mif.meas_valid, mif.edge_count, old);
    end
    set_enable(1'b1);
    run(LAT_EN + GLEN - 1);
    checks++;
    if (mif.meas_valid !== 1'b0) begin
      errors++; $display("FAIL reenable_early valid=%b required 0", mif.meas_valid);
    end
    run(1);
    checks++;
    if (mif.meas_valid !== 1'b1 || mif.edge_count !== 9'(rises(cyc - GLEN - 2, cyc - 3))) begin
      errors++;
      $display("FAIL reenable_result valid=%b count=%0d required 1/%0d",
               mif.meas_valid, mif.edge_count, rises(cyc - GLEN - 2, cyc - 3));
    end
  endtask

  task automatic test_reset_mid();
    int e;
    rdy_mode = 0; mif.meas_ready = 1'b0; sig_mode = 3;
    run(next_result() - cyc + 50);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    checks++;
    if (mif.meas_valid !== 1'b0 || mif.overrun !== 1'b0 ||
        mif.edge_count !== 9'd0 || mif.phase_inc_meas !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid valid=%b overrun=%b count=%0d phase=%h required all zero",
               mif.meas_valid, mif.overrun, mif.edge_count, mif.phase_inc_meas);
    end
    e = cyc;
    rdy_mode = 1;
    run(e + LAT_EN + GLEN - cyc);
    checks++;
    if (mif.meas_valid !== 1'b1) begin
      errors++; $display("FAIL reset_restart valid=%b required 1", mif.meas_valid);
    end
    run(3);
  endtask

  initial begin
    mif.meas_ready = 1'b0;
    hist[0] = 1'b0;
    test_reset();
    test_period16();
    test_toggle_and_constant();
    test_random();
    test_terminal_edge();
    test_backpressure();
    test_enable_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nco_freq_meter.md
# nco_freq_meter

Reciprocal companion to the NCO phase accumulator: measures the frequency of an external 1-bit signal (comparator/limiter output of the RF path) and reports it directly as a 64-bit phase-increment word in the same units as the NCO tuning input. An NCO loaded with that word reproduces the measured frequency. It sits beside the NCO in the SDR peripheral and lets software close a frequency-lock loop or calibrate the carrier without any division.

## Interface
- GATE_LOG2, 24, gate length is 2^GATE_LOG2 clk cycles; legal range 4..63
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- enable  in  1  1 = run back-to-back gates; 0 = abort current gate and idle
- sig_in  in  1  asynchronous input signal to measure
- phase_inc_meas  out  64  measured tuning word, edge_count << (64-GATE_LOG2)
- edge_count  out  GATE_LOG2+1  raw rising-edge count of the last completed gate
- meas_valid  out  1  result available, held until accepted
- meas_ready  in  1  consumer accepts result when meas_valid && meas_ready
- overrun  out  1  sticky: a new result overwrote an unaccepted one

## Operation
- Input path: 2-FF synchronizer on sig_in, then one delay register; rising edge = sync & ~delay.
- States: IDLE, SETTLE, GATE.
  - IDLE: counters cleared. enable=1 -> SETTLE.
  - SETTLE: 3 cycles to flush the synchronizer; edges ignored. -> GATE.
  - GATE: gate_cnt (GATE_LOG2 bits) counts 0..2^GATE_LOG2-1; edge_acc (GATE_LOG2+1 bits) counts rising edges. On terminal count, the result is latched, accumulators restart, and the FSM stays in GATE.
- An edge on the terminal-count cycle belongs to the ending gate. The next gate starts on the following cycle, so there are no dead cycles.
- Result latch: edge_count <= edge_acc (including a terminal-cycle edge); phase_inc_meas <= zero-extended count shifted left by 64-GATE_LOG2, truncated to 64 bits. meas_valid <= 1.
- If meas_valid was already 1 and no handshake happened that cycle, overrun <= 1.
- Handshake: meas_valid && meas_ready clears meas_valid and overrun on the next cycle. If a latch and a handshake happen in the same cycle, the latch wins: meas_valid stays 1, overrun is not set, and the old result counts as consumed.
- enable=0 in any state -> IDLE next cycle. The partial gate is discarded. Latched outputs, meas_valid and overrun are kept.
- Max countable rate is clk/2 after synchronizing, so edge_acc never exceeds 2^(GATE_LOG2-1). The extra MSB exists only for safety.

## Timing
- Reset (rst_n=0 at a clk edge): FSM=IDLE; phase_inc_meas=0, edge_count=0, meas_valid=0, overrun=0; synchronizer and counters = 0.
- Reset asserted mid-gate has the same effect. The partial gate is lost.
- sig_in rising -> counted edge: 3 clk latency.
- enable rise -> first GATE cycle: 4 cycles (1 to leave IDLE, 3 in SETTLE).
- First meas_valid: 2^GATE_LOG2 cycles after GATE entry, registered. Subsequent results follow every 2^GATE_LOG2 cycles exactly.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package (sdr_pkg) holds:
  - PHASE_W = 64, shared with the NCO.
  - FSM state enum {IDLE, SETTLE, GATE}.
- Sub-module: sig_sync_edge (2-FF synchronizer + rising-edge detector), reusable for other async SDR inputs.
- Everything else (FSM, gate counter, accumulator, result/handshake regs) lives in nco_freq_meter.

## Test plan
- GATE_LOG2=8, sig_in period 16 cycles, enable=1, meas_ready=1 -> every 256 cycles edge_count=16, phase_inc_meas=0x1000_0000_0000_0000, overrun=0.
- sig_in toggling every cycle (period 2) -> edge_count=128, phase_inc_meas=0x8000_0000_0000_0000; sig_in constant -> edge_count=0, phase_inc_meas=0.
- Edge placed exactly on the terminal-count cycle -> counted in the ending gate; the next gate count excludes it.
- meas_ready=0 across two gates -> meas_valid stays 1, overrun=1, second result visible. Then meas_ready=1 for one cycle -> meas_valid=0, overrun=0.
- enable dropped at gate cycle 100 -> IDLE, no new meas_valid, old result kept. Re-enable -> first result 4+256 cycles later.
- rst_n=0 for one cycle mid-gate with meas_valid=1 -> all outputs 0 next cycle, FSM IDLE.
